// File: rtl/matrix_scan_driver.sv
// Row-scanning driver for a 5x5 bicolor matrix: double-buffered 50-bit frame,
// blank/drive row sequencing with dead time, registered active-low row grounds.
module matrix_scan_driver #(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [49:0] frame_in,
  input  logic        frame_load,
  input  logic        enable,
  output logic [4:0]  green,
  output logic [4:0]  red,
  output logic [4:0]  gnd,
  output logic [2:0]  row_idx,
  output logic        frame_start
);

  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t        state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [2:0]    row_q, row_n;
  logic [49:0]   shadow_q, active_q;
  logic          pending_q;
  logic          swap_now;
  logic [9:0]    row_slice;
  logic [4:0]    gnd_n, red_n, green_n;
  logic [2:0]    row_idx_n;
  logic          frame_start_n;

  assign row_slice = active_q[int'(row_q) * 10 +: 10];

  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    row_n    = row_q;
    swap_now = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      cnt_n   = '0;
      row_n   = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_n = BLANK;
          cnt_n   = '0;
          row_n   = 3'd0;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_n  = DRIVE;
            cnt_n    = '0;
            swap_now = (row_q == 3'd0);
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
        DRIVE: begin
          if (cnt_q == DWELL_LAST) begin
            state_n = BLANK;
            cnt_n   = '0;
            row_n   = (row_q == 3'd4) ? 3'd0 : row_q + 3'd1;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
          row_n   = 3'd0;
        end
      endcase
    end
  end

  // Output registers follow the state one cycle later; disable blanks at once.
  always_comb begin
    gnd_n         = 5'b11111;
    red_n         = 5'b00000;
    green_n       = 5'b00000;
    frame_start_n = 1'b0;
    row_idx_n     = enable ? row_q : 3'd0;
    if (enable && state_q == DRIVE) begin
      gnd_n = ~(5'b00001 << row_q);
      for (int c = 0; c < 5; c++) begin
        green_n[c] = row_slice[2*c];
        red_n[c]   = row_slice[2*c+1];
      end
      frame_start_n = (row_q == 3'd0) && (cnt_q == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      row_q       <= 3'd0;
      shadow_q    <= '0;
      active_q    <= '0;
      pending_q   <= 1'b0;
      gnd         <= 5'b11111;
      red         <= 5'b00000;
      green       <= 5'b00000;
      row_idx     <= 3'd0;
      frame_start <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      row_q       <= row_n;
      gnd         <= gnd_n;
      red         <= red_n;
      green       <= green_n;
      row_idx     <= row_idx_n;
      frame_start <= frame_start_n;
      if (frame_load) begin
        shadow_q  <= frame_in;
        pending_q <= 1'b1;
      end
      // A load landing on the swap cycle goes straight to the active buffer.
      if (swap_now) begin
        pending_q <= 1'b0;
        if (frame_load)
          active_q <= frame_in;
        else if (pending_q)
          active_q <= shadow_q;
      end
    end
  end

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Directed bench for matrix_scan_driver with DWELL_CYCLES=8, BLANK_CYCLES=2.
module tb_matrix_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [49:0] frame_in;
  logic        frame_load;
  logic        enable;
  logic [4:0]  green, red, gnd;
  logic [2:0]  row_idx;
  logic        frame_start;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [49:0] FR_A = {25{2'b01}};
  localparam logic [49:0] FR_P = 50'h8000;
  localparam logic [49:0] FR_R = {25{2'b10}};
  localparam logic [49:0] FR_Q = {25{2'b11}};
  localparam logic [49:0] FR_B = 50'h139;

  matrix_scan_driver #(.DWELL_CYCLES(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .frame_in(frame_in), .frame_load(frame_load),
    .enable(enable), .green(green), .red(red), .gnd(gnd),
    .row_idx(row_idx), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [4:0] eg, input logic [4:0] egr,
                         input logic [4:0] erd, input logic [2:0] eri, input logic efs);
    chk({tag, " gnd"}, gnd, eg);
    chk({tag, " green"}, green, egr);
    chk({tag, " red"}, red, erd);
    chk({tag, " row_idx"}, {2'b00, row_idx}, {2'b00, eri});
    chk({tag, " frame_start"}, {4'b0000, frame_start}, {4'b0000, efs});
  endtask

  // One row: 2 blank cycles then 8 drive cycles; optional load before cycle ld_at.
  task automatic run_row(input int r, input logic [4:0] eg, input logic [4:0] er,
                         input int ld_at, input logic [49:0] ld_val, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      if (i == ld_at) begin
        frame_in   = ld_val;
        frame_load = 1'b1;
      end
      tick();
      frame_load = 1'b0;
      if (i < 2)
        chk_all($sformatf("row%0d blank%0d", r, i), 5'b11111, 5'b0, 5'b0, 3'(r), 1'b0);
      else
        chk_all($sformatf("row%0d drive%0d", r, i - 2), ~(5'b00001 << r), eg, er, 3'(r),
                (i == 2) && (r == 0));
    end
  endtask

  initial begin
    reset = 1'b1;
    frame_in = '0;
    frame_load = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      frame_in   = {$urandom, $urandom};
      frame_load = 1'($urandom_range(0, 1));
      enable     = 1'($urandom_range(0, 1));
      tick();
      chk_all($sformatf("reset%0d", i), 5'b11111, 5'b0, 5'b0, 3'd0, 1'b0);
    end
    reset = 1'b0;
    enable = 1'b0;
    frame_load = 1'b0;
    tick();
    chk_all("idle", 5'b11111, 5'b0, 5'b0, 3'd0, 1'b0);

    // Load all-green, then start scanning
    frame_in = FR_A;
    frame_load = 1'b1;
    tick();
    frame_load = 1'b0;
    chk_all("load_a", 5'b11111, 5'b0, 5'b0, 3'd0, 1'b0);
    enable = 1'b1;
    tick();
    chk_all("enable_edge", 5'b11111, 5'b0, 5'b0, 3'd0, 1'b0);
    for (int r = 0; r < 5; r++) run_row(r, 5'b11111, 5'b0, -1, '0, 10);
    run_row(0, 5'b11111, 5'b0, -1, '0, 10);

    // Single red pixel at row 1, column 2; loaded mid-frame
    run_row(1, 5'b11111, 5'b0, 0, FR_P, 10);
    for (int r = 2; r < 5; r++) run_row(r, 5'b11111, 5'b0, -1, '0, 10);
    run_row(0, 5'b0, 5'b0, -1, '0, 10);
    run_row(1, 5'b0, 5'b00100, -1, '0, 10);
    // All-red loaded while row 2 is driven: takes effect only at next row 0
    run_row(2, 5'b0, 5'b0, 4, FR_R, 10);
    run_row(3, 5'b0, 5'b0, -1, '0, 10);
    run_row(4, 5'b0, 5'b0, -1, '0, 10);
    run_row(0, 5'b0, 5'b11111, -1, '0, 10);
    run_row(1, 5'b0, 5'b11111, -1, '0, 10);
    run_row(2, 5'b0, 5'b11111, -1, '0, 10);
    run_row(3, 5'b0, 5'b11111, -1, '0, 5);

    // Enable drop in row 3 drive; a load during disable stays pending
    enable = 1'b0;
    frame_in = FR_Q;
    frame_load = 1'b1;
    tick();
    frame_load = 1'b0;
    chk_all("disable0", 5'b11111, 5'b0, 5'b0, 3'd0, 1'b0);
    tick();
    chk_all("disable1", 5'b11111, 5'b0, 5'b0, 3'd0, 1'b0);
    enable = 1'b1;
    tick();
    chk_all("reenable", 5'b11111, 5'b0, 5'b0, 3'd0, 1'b0);
    run_row(0, 5'b11111, 5'b11111, -1, '0, 10);
    run_row(1, 5'b11111, 5'b11111, -1, '0, 10);
    run_row(2, 5'b11111, 5'b11111, 3, FR_A, 10);
    run_row(3, 5'b11111, 5'b11111, -1, '0, 10);
    run_row(4, 5'b11111, 5'b11111, -1, '0, 10);

    // Load B on the last row-0 blank cycle: bypasses pending A
    run_row(0, 5'b10101, 5'b00110, 1, FR_B, 10);
    for (int r = 1; r < 5; r++) run_row(r, 5'b0, 5'b0, -1, '0, 10);
    run_row(0, 5'b10101, 5'b00110, -1, '0, 10);
    run_row(1, 5'b0, 5'b0, -1, '0, 5);

    // Reset in the middle of a drive clears everything
    reset = 1'b1;
    tick();
    chk_all("mid_reset", 5'b11111, 5'b0, 5'b0, 3'd0, 1'b0);
    reset = 1'b0;
    tick();
    chk_all("post_reset", 5'b11111, 5'b0, 5'b0, 3'd0, 1'b0);
    run_row(0, 5'b0, 5'b0, -1, '0, 10);
    run_row(1, 5'b0, 5'b0, -1, '0, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
